// File: rtl/time_of_day.sv
// Time-of-day keeper: hour/minute/second driven by the 1 kHz tick, with per-field
// set buttons that act on release, plus second and midnight tick pulses.
module time_of_day #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int RST_HOUR      = 0,
  parameter int RST_MIN       = 0,
  parameter int RST_SEC       = 0
) (
  input  logic       rst,
  input  logic       clk1000,
  input  logic       i_h,
  input  logic       d_h,
  input  logic       i_mi,
  input  logic       d_mi,
  input  logic       i_s,
  input  logic       d_s,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       sec_tick,
  output logic       day_tick
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_TERM = SUB_W'(TICKS_PER_SEC - 1);

  // Step a field by one in either direction, wrapping inside 0..maxv.
  // Both directions at once leave the value alone.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] maxv,
                                           input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up && !dn)
      r = (v == maxv) ? 6'd0 : v + 6'd1;
    else if (dn && !up)
      r = (v == 6'd0) ? maxv : v - 6'd1;
    return r;
  endfunction

  logic [SUB_W-1:0] sub_cnt, sub_nxt;
  logic [5:0]       btn, btn_flag, rel;
  logic             rel_any, rel_sec, at_term;
  logic [4:0]       hour_nxt;
  logic [5:0]       min_nxt, sec_nxt, hour_w;
  logic             sec_tick_nxt, day_tick_nxt;

  assign btn     = {d_s, i_s, d_mi, i_mi, d_h, i_h};
  assign rel     = btn_flag & ~btn;
  assign rel_any = |rel;
  assign rel_sec = rel[4] | rel[5];
  assign at_term = (sub_cnt == SUB_TERM);

  // A release on the terminal count holds the counter there, deferring the
  // natural advance one cycle; a second adjust instead restarts the second.
  always_comb begin
    sub_nxt      = sub_cnt;
    hour_nxt     = hour;
    min_nxt      = minute;
    sec_nxt      = second;
    hour_w       = 6'd0;
    sec_tick_nxt = 1'b0;
    day_tick_nxt = 1'b0;
    if (rel_any) begin
      hour_w   = wrap_step({1'b0, hour}, 6'd23, rel[0], rel[1]);
      hour_nxt = hour_w[4:0];
      min_nxt  = wrap_step(minute, 6'd59, rel[2], rel[3]);
      sec_nxt  = wrap_step(second, 6'd59, rel[4], rel[5]);
      if (rel_sec)
        sub_nxt = '0;
      else if (!at_term)
        sub_nxt = sub_cnt + SUB_W'(1);
    end else if (at_term) begin
      sub_nxt      = '0;
      sec_tick_nxt = 1'b1;
      sec_nxt      = wrap_step(second, 6'd59, 1'b1, 1'b0);
      if (second == 6'd59) begin
        min_nxt = wrap_step(minute, 6'd59, 1'b1, 1'b0);
        if (minute == 6'd59) begin
          hour_w       = wrap_step({1'b0, hour}, 6'd23, 1'b1, 1'b0);
          hour_nxt     = hour_w[4:0];
          day_tick_nxt = (hour == 5'd23);
        end
      end
    end else begin
      sub_nxt = sub_cnt + SUB_W'(1);
    end
  end

  always_ff @(posedge clk1000 or negedge rst) begin
    if (!rst) begin
      sub_cnt  <= '0;
      btn_flag <= '0;
      hour     <= 5'(RST_HOUR);
      minute   <= 6'(RST_MIN);
      second   <= 6'(RST_SEC);
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      sub_cnt  <= sub_nxt;
      btn_flag <= btn;
      hour     <= hour_nxt;
      minute   <= min_nxt;
      second   <= sec_nxt;
      sec_tick <= sec_tick_nxt;
      day_tick <= day_tick_nxt;
    end
  end

endmodule

// File: tb/tb_time_of_day.sv
// Bench for time_of_day: two instances (reset at 00:00:00 and 23:59:59) checked each
// cycle against a seconds-of-day model, plus directed literal checks.
module tb_time_of_day;
  localparam int T = 4;

  logic clk1000 = 1'b0;
  logic rst = 1'b1;
  logic i_h = 1'b0, d_h = 1'b0, i_mi = 1'b0, d_mi = 1'b0, i_s = 1'b0, d_s = 1'b0;
  logic [4:0] a_hour, b_hour;
  logic [5:0] a_minute, a_second, b_minute, b_second;
  logic a_sec_tick, a_day_tick, b_sec_tick, b_day_tick;

  always #5 clk1000 = ~clk1000;

  time_of_day #(.TICKS_PER_SEC(T), .RST_HOUR(0), .RST_MIN(0), .RST_SEC(0)) dut_a (
    .rst(rst), .clk1000(clk1000), .i_h(i_h), .d_h(d_h), .i_mi(i_mi), .d_mi(d_mi),
    .i_s(i_s), .d_s(d_s), .hour(a_hour), .minute(a_minute), .second(a_second),
    .sec_tick(a_sec_tick), .day_tick(a_day_tick));

  time_of_day #(.TICKS_PER_SEC(T), .RST_HOUR(23), .RST_MIN(59), .RST_SEC(59)) dut_b (
    .rst(rst), .clk1000(clk1000), .i_h(i_h), .d_h(d_h), .i_mi(i_mi), .d_mi(d_mi),
    .i_s(i_s), .d_s(d_s), .hour(b_hour), .minute(b_minute), .second(b_second),
    .sec_tick(b_sec_tick), .day_tick(b_day_tick));

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time kept as plain integers, advances via seconds-of-day.
  int rh[2] = '{0, 23};
  int rm[2] = '{0, 59};
  int rs[2] = '{0, 59};
  int mh[2], mm[2], ms[2], msub[2];
  bit mst[2], mdt[2];
  bit [5:0] mflag;

  task automatic model_step(input int k, input bit [5:0] rel);
    int t;
    mst[k] = 1'b0;
    mdt[k] = 1'b0;
    if (rel != 6'd0) begin
      mh[k] = (mh[k] + int'(rel[0]) - int'(rel[1]) + 24) % 24;
      mm[k] = (mm[k] + int'(rel[2]) - int'(rel[3]) + 60) % 60;
      ms[k] = (ms[k] + int'(rel[4]) - int'(rel[5]) + 60) % 60;
      if (rel[4] || rel[5]) msub[k] = 0;
      else if (msub[k] != T - 1) msub[k] = msub[k] + 1;
    end else if (msub[k] == T - 1) begin
      t = mh[k] * 3600 + mm[k] * 60 + ms[k] + 1;
      if (t == 86400) begin
        mdt[k] = 1'b1;
        t = 0;
      end
      mh[k] = t / 3600;
      mm[k] = (t / 60) % 60;
      ms[k] = t % 60;
      msub[k] = 0;
      mst[k] = 1'b1;
    end else begin
      msub[k] = msub[k] + 1;
    end
  endtask

  always @(posedge clk1000 or negedge rst) begin : model
    bit [5:0] b;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mh[k] = rh[k]; mm[k] = rm[k]; ms[k] = rs[k]; msub[k] = 0;
        mst[k] = 1'b0; mdt[k] = 1'b0;
      end
      mflag = 6'd0;
    end else begin
      b = {d_s, i_s, d_mi, i_mi, d_h, i_h};
      for (int k = 0; k < 2; k++) model_step(k, mflag & ~b);
      mflag = b;
    end
  end

  always @(negedge clk1000) begin
    if (cmp_en) begin
      chk("a.hour", a_hour, mh[0]);       chk("b.hour", b_hour, mh[1]);
      chk("a.minute", a_minute, mm[0]);   chk("b.minute", b_minute, mm[1]);
      chk("a.second", a_second, ms[0]);   chk("b.second", b_second, ms[1]);
      chk("a.sec_tick", a_sec_tick, mst[0]); chk("b.sec_tick", b_sec_tick, mst[1]);
      chk("a.day_tick", a_day_tick, mdt[0]); chk("b.day_tick", b_day_tick, mdt[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk1000);
    #1;
  endtask

  initial begin
    int cnt, h0, m0, s0, n;
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk1000); @(posedge clk1000); #1 rst = 1'b1;
    chk("rst.a.hour", a_hour, 0); chk("rst.a.second", a_second, 0);
    chk("rst.b.hour", b_hour, 23); chk("rst.b.minute", b_minute, 59);
    chk("rst.b.second", b_second, 59); chk("rst.a.sec_tick", a_sec_tick, 0);

    // first second and midnight rollover
    cyc(4);
    chk("t1.a.second", a_second, 1); chk("t1.a.sec_tick", a_sec_tick, 1);
    chk("t2.b.hour", b_hour, 0); chk("t2.b.minute", b_minute, 0);
    chk("t2.b.second", b_second, 0); chk("t2.b.day_tick", b_day_tick, 1);
    chk("t2.b.sec_tick", b_sec_tick, 1);
    cyc(1);
    chk("t1.a.sec_tick_low", a_sec_tick, 0); chk("t2.b.day_tick_low", b_day_tick, 0);
    cnt = 0;
    repeat (20) begin cyc(1); cnt += int'(b_day_tick); end
    chk("t2.no_extra_day_tick", cnt, 0);
    cyc(215);
    chk("t1.a.minute_240", a_minute, 1); chk("t1.a.second_240", a_second, 0);

    // hold hour button, single increment on release
    h0 = a_hour;
    i_h = 1'b1; cyc(10); i_h = 1'b0;
    cyc(1);
    chk("t3.hold_release", a_hour, (h0 + 1) % 24);
    cyc(6);
    chk("t3.no_repeat", a_hour, (h0 + 1) % 24);

    // reset while hour button held; flag must not survive reset
    i_h = 1'b1; cyc(3); #2 rst = 1'b0;
    @(posedge clk1000); #1 i_h = 1'b0; #1 rst = 1'b1;
    chk("t6.a.hour", a_hour, 0); chk("t6.a.minute", a_minute, 0);
    chk("t6.b.hour", b_hour, 23); chk("t6.b.second", b_second, 59);
    cyc(1);
    chk("t6.a.hour_no_change", a_hour, 0); chk("t6.b.hour_no_change", b_hour, 23);
    i_h = 1'b1; cyc(1); i_h = 1'b0; cyc(1);
    chk("t3.b.hour_wrap", b_hour, 0); chk("t3.b.minute", b_minute, 59);
    chk("t3.b.second", b_second, 59); chk("t3.b.day_tick", b_day_tick, 0);
    chk("t3.b.sec_tick", b_sec_tick, 0);
    cyc(1);
    chk("t3.b.next_hour", b_hour, 1); chk("t3.b.next_day_tick", b_day_tick, 0);

    // minute decrement wrap, then simultaneous second inc/dec
    d_mi = 1'b1; cyc(1); d_mi = 1'b0; cyc(1);
    chk("t4.minute_wrap", a_minute, 59); chk("t4.hour_same", a_hour, 1);
    i_s = 1'b1; d_s = 1'b1; cyc(1); i_s = 1'b0; d_s = 1'b0;
    s0 = a_second;
    cyc(1);
    chk("t4.second_same", a_second, s0);
    n = 0;
    do begin cyc(1); n++; end while (!a_sec_tick && n < 10);
    chk("t4.sub_cleared_spacing", n, 4);

    // minute release on terminal count defers the second by one cycle
    i_mi = 1'b1; cyc(3); i_mi = 1'b0;
    m0 = a_minute; s0 = a_second;
    cyc(1);
    chk("t5.minute_inc", a_minute, (m0 + 1) % 60); chk("t5.second_held", a_second, s0);
    chk("t5.no_tick", a_sec_tick, 0);
    cyc(1);
    chk("t5.second_late", a_second, (s0 + 1) % 60); chk("t5.late_tick", a_sec_tick, 1);
    n = 0;
    do begin cyc(1); n++; end while (!a_sec_tick && n < 10);
    chk("t5.spacing", n, 4);

    // randomized buttons with occasional resets
    repeat (3000) begin
      cyc(1);
      i_h  = ($urandom_range(0, 7) == 0); d_h  = ($urandom_range(0, 7) == 0);
      i_mi = ($urandom_range(0, 7) == 0); d_mi = ($urandom_range(0, 7) == 0);
      i_s  = ($urandom_range(0, 9) == 0); d_s  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        @(posedge clk1000); #1 rst = 1'b1;
      end
    end
    {i_h, d_h, i_mi, d_mi, i_s, d_s} = 6'd0;
    cyc(20);
    @(negedge clk1000); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
